// File: rtl/learning_sequencer.sv
// Learning-mode scheduler: demonstrates each song note, then waits for the
// player to press the matching key, counting hits and timeouts.
module learning_sequencer #(
  parameter int SONG_LEN       = 25,
  parameter int GAP_CYCLES     = 50000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  user_input,
  input  logic [3:0]  mem_note,
  input  logic [25:0] mem_duration,
  output logic [4:0]  mem_addr,
  output logic        key_on,
  output logic [3:0]  key,
  output logic [4:0]  score,
  output logic        hit,
  output logic        miss,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0]  LAST_ADDR = 5'(SONG_LEN - 1);
  localparam logic [27:0] GAP_LAST  = 28'(GAP_CYCLES - 1);
  localparam logic [27:0] TO_LAST   = 28'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PLAY, S_GAP, S_WAIT, S_ADV, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [27:0] counter_reg, counter_next;
  logic [3:0]  note_reg, note_next;
  logic [25:0] dur_reg, dur_next;
  logic        armed_reg, armed_next;
  logic [4:0]  addr_reg, addr_next;
  logic        key_on_reg, key_on_next;
  logic [3:0]  key_reg, key_next;
  logic [4:0]  score_reg, score_next;
  logic        hit_reg, hit_next;
  logic        miss_reg, miss_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic active;
  logic match;
  logic play_end;

  assign active   = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign match    = armed_reg && (user_input == note_reg);
  assign play_end = (counter_reg[25:0] + 26'd1) == dur_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      counter_reg <= '0;
      note_reg    <= '0;
      dur_reg     <= '0;
      armed_reg   <= 1'b0;
      addr_reg    <= '0;
      key_on_reg  <= 1'b0;
      key_reg     <= '0;
      score_reg   <= '0;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      note_reg    <= note_next;
      dur_reg     <= dur_next;
      armed_reg   <= armed_next;
      addr_reg    <= addr_next;
      key_on_reg  <= key_on_next;
      key_reg     <= key_next;
      score_reg   <= score_next;
      hit_reg     <= hit_next;
      miss_reg    <= miss_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    note_next  = note_reg;
    dur_next   = dur_reg;
    addr_next  = addr_reg;
    score_next = score_reg;
    armed_next = 1'b0;
    hit_next   = 1'b0;
    miss_next  = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_FETCH;
          addr_next  = '0;
          score_next = '0;
        end
      end
      S_FETCH: begin
        note_next  = mem_note;
        dur_next   = mem_duration;
        state_next = (mem_duration != 26'd0) ? S_PLAY : S_GAP;
      end
      S_PLAY: begin
        if (play_end) state_next = S_GAP;
      end
      S_GAP: begin
        if (counter_reg == GAP_LAST) state_next = (note_reg != 4'd0) ? S_WAIT : S_ADV;
      end
      S_WAIT: begin
        // A key already held when WAIT begins must be released before it counts.
        armed_next = armed_reg | (user_input == 4'd0);
        if (match) begin
          hit_next   = 1'b1;
          score_next = (score_reg == 5'd31) ? 5'd31 : score_reg + 5'd1;
          state_next = S_ADV;
        end else if (counter_reg == TO_LAST) begin
          miss_next  = 1'b1;
          state_next = S_ADV;
        end
      end
      S_ADV: begin
        if (addr_reg == LAST_ADDR) begin
          state_next = S_DONE;
        end else begin
          addr_next  = addr_reg + 5'd1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (abort && active) begin
      state_next = S_IDLE;
      addr_next  = '0;
      score_next = score_reg;
      armed_next = 1'b0;
      hit_next   = 1'b0;
      miss_next  = 1'b0;
    end

    // Outputs are decoded from the next state so they line up with it.
    key_on_next = (state_next == S_PLAY);
    key_next    = ((state_next == S_PLAY) || (state_next == S_GAP)) ? note_next : 4'd0;
    busy_next   = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next   = (state_next == S_DONE);

    if ((state_next == state_reg) &&
        ((state_reg == S_PLAY) || (state_reg == S_GAP) || (state_reg == S_WAIT)))
      counter_next = counter_reg + 28'd1;
    else
      counter_next = '0;
  end

  assign mem_addr = addr_reg;
  assign key_on   = key_on_reg;
  assign key      = key_reg;
  assign score    = score_reg;
  assign hit      = hit_reg;
  assign miss     = miss_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_learning_sequencer.sv
// Directed bench: a 3-entry song with short timing, plus a 32-entry song
// that drives the score into saturation.
module tb_learning_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, abort_a, start_b, abort_b;
  logic [3:0]  ui_a, ui_b;
  logic [3:0]  note_a, note_b;
  logic [25:0] dur_a, dur_b;
  logic [4:0]  addr_a, addr_b, score_a, score_b;
  logic [3:0]  key_a, key_b;
  logic        key_on_a, hit_a, miss_a, busy_a, done_a;
  logic        key_on_b, hit_b, miss_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  learning_sequencer #(.SONG_LEN(3), .GAP_CYCLES(4), .TIMEOUT_CYCLES(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .user_input(ui_a),
    .mem_note(note_a), .mem_duration(dur_a), .mem_addr(addr_a), .key_on(key_on_a),
    .key(key_a), .score(score_a), .hit(hit_a), .miss(miss_a), .busy(busy_a), .done(done_a)
  );

  learning_sequencer #(.SONG_LEN(32), .GAP_CYCLES(1), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .user_input(ui_b),
    .mem_note(note_b), .mem_duration(dur_b), .mem_addr(addr_b), .key_on(key_on_b),
    .key(key_b), .score(score_b), .hit(hit_b), .miss(miss_b), .busy(busy_b), .done(done_b)
  );

  // Song {(5,3),(0,2),(7,0)}; the second song is every entry (1,1).
  always_comb begin
    case (addr_a)
      5'd0:    begin note_a = 4'd5; dur_a = 26'd3; end
      5'd1:    begin note_a = 4'd0; dur_a = 26'd2; end
      5'd2:    begin note_a = 4'd7; dur_a = 26'd0; end
      default: begin note_a = 4'd0; dur_a = 26'd0; end
    endcase
  end
  assign note_b = 4'd1;
  assign dur_b  = 26'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("check %s: got=%0d", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int early_miss;
    int hits;
    int misses;
    rst = 1'b1; start_a = 0; abort_a = 0; ui_a = 0; start_b = 0; abort_b = 0; ui_b = 0;
    #12;
    chk("rst_addr", addr_a, 0);
    chk("rst_key_on", key_on_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_score", score_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Entry 0: note 5 for 3 cycles, 4-cycle gap, then answer 0 -> 5.
    start_a = 1; tick; start_a = 0;
    chk("t1_fetch_busy", busy_a, 1);
    chk("t1_fetch_key_on", key_on_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t1_play_key_on", key_on_a, 1);
      chk("t1_play_key", key_a, 5);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t1_gap_key_on", key_on_a, 0);
      chk("t1_gap_key", key_a, 5);
    end
    tick;
    chk("t1_wait_key", key_a, 0);
    tick;
    chk("t1_armed_no_hit", hit_a, 0);
    ui_a = 5; tick;
    chk("t1_hit", hit_a, 1);
    chk("t1_score", score_a, 1);
    ui_a = 0; tick;
    chk("t1_hit_pulse_end", hit_a, 0);
    chk("t1_addr_next", addr_a, 1);

    // Entry 1: rest, key_on with key 0, no WAIT.
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("t2_rest_key_on", key_on_a, 1);
      chk("t2_rest_key", key_a, 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t2_gap_key_on", key_on_a, 0);
    end
    tick;
    chk("t2_adv_addr", addr_a, 1);
    chk("t2_no_hit", hit_a, 0);
    chk("t2_no_miss", miss_a, 0);
    tick;
    chk("t2_addr_2", addr_a, 2);

    // Entry 2: zero duration goes straight to GAP; no answer -> miss.
    tick;
    chk("t3_gap_direct_key_on", key_on_a, 0);
    chk("t3_gap_direct_key", key_a, 7);
    tick(3);
    tick;
    chk("t3_wait_key", key_a, 0);
    early_miss = 0;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (miss_a) early_miss++;
    end
    chk("t3_no_early_miss", early_miss, 0);
    tick;
    chk("t3_miss", miss_a, 1);
    chk("t3_miss_no_hit", hit_a, 0);
    tick;
    chk("t3_done", done_a, 1);
    chk("t3_busy", busy_a, 0);
    chk("t3_score", score_a, 1);
    chk("t3_addr", addr_a, 2);
    chk("t3_miss_pulse_end", miss_a, 0);

    // Key held from before WAIT, wrong key, start ignored while busy.
    ui_a = 5; start_a = 1; tick; start_a = 0;
    chk("t4_score_cleared", score_a, 0);
    chk("t4_addr_cleared", addr_a, 0);
    chk("t4_done_cleared", done_a, 0);
    tick;
    start_a = 1; tick; start_a = 0;
    chk("t5_start_ignored", key_on_a, 1);
    tick(2);
    chk("t4_gap_key_on", key_on_a, 0);
    tick(4);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_held_no_hit", hit_a, 0);
    end
    ui_a = 3; tick;
    chk("t4_wrong_unarmed", hit_a, 0);
    ui_a = 0; tick;
    chk("t4_release", hit_a, 0);
    ui_a = 3; tick;
    chk("t4_wrong_hit", hit_a, 0);
    chk("t4_wrong_miss", miss_a, 0);
    ui_a = 5; tick;
    chk("t4_hit", hit_a, 1);
    chk("t4_score", score_a, 1);
    ui_a = 0;

    // Abort mid-GAP together with start: abort wins, score kept.
    tick(3);
    tick;
    chk("t5_gap_key_on", key_on_a, 0);
    chk("t5_gap_addr", addr_a, 1);
    abort_a = 1; start_a = 1; tick; abort_a = 0; start_a = 0;
    chk("t5_abort_busy", busy_a, 0);
    chk("t5_abort_key", key_a, 0);
    chk("t5_abort_addr", addr_a, 0);
    chk("t5_abort_score", score_a, 1);
    chk("t5_abort_done", done_a, 0);
    tick;
    chk("t5_still_idle", busy_a, 0);

    // Asynchronous reset mid-PLAY.
    start_a = 1; tick; start_a = 0;
    tick;
    chk("t5_play_key_on", key_on_a, 1);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_play_key_on", key_on_a, 0);
    chk("t5_rst_play_busy", busy_a, 0);
    chk("t5_rst_play_key", key_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Asynchronous reset mid-WAIT.
    start_a = 1; tick; start_a = 0;
    tick(3);
    tick(4);
    tick;
    chk("t5_wait_busy", busy_a, 1);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_wait_busy", busy_a, 0);
    chk("t5_rst_wait_addr", addr_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Saturation: 32 hits, score holds at 31 while hit still pulses.
    hits = 0;
    misses = 0;
    start_b = 1; tick; start_b = 0;
    for (int c = 0; c < 600 && !done_b; c++) begin
      ui_b = (ui_b == 4'd0) ? 4'd1 : 4'd0;
      tick;
      if (miss_b) misses++;
      if (hit_b) begin
        hits++;
        chk("t6_score", score_b, (hits > 31) ? 31 : hits);
      end
    end
    chk("t6_done", done_b, 1);
    chk("t6_hits", hits, 32);
    chk("t6_misses", misses, 0);
    chk("t6_final_score", score_b, 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
